intersection_phase_scheduler: RTL and testbench

Demand-driven phase scheduler for a two-way intersection: sequences NS/EW green, yellow and all-red clearance phases, latches pedestrian crossing requests, and supports emergency-vehicle preemption. It extends the fixed-cycle light controller with:
- vehicle-actuated green lengths,
- rest-in-green,
- pedestrian walk intervals,
- a preempt override.

It drives the six lamp outputs and two walk lamps directly and exports its phase for monitoring.

---
 rtl/intersection_phase_scheduler.sv | 244 ++++++++++++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_scheduler.sv
// Demand-driven phase scheduler for a two-way intersection.
// Sequences NS/EW green, yellow and all-red clearance phases with
// vehicle-actuated green lengths and rest-in-green. Pedestrian requests
// are latched and served with a walk interval at the start of the next
// green for that direction. Emergency preemption parks the intersection
// in PRE_G, green for the requested direction.
module intersection_phase_scheduler #(
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 24,
    parameter int YELLOW    = 4,
    parameter int ALL_RED   = 2,
    parameter int WALK      = 8,
    parameter int TW        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_ns_req,
    input  logic       ped_ew_req,
    input  logic       emerg_req,
    input  logic       emerg_dir,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       ns_walk,
    output logic       ew_walk,
    output logic       ped_ns_pending,
    output logic       ped_ew_pending,
    output logic       preempt_active,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR1   = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR2   = 3'd5,
        PRE_G = 3'd6
    } state_t;

    // Terminal timer values: a phase ends when the timer reaches these.
    localparam logic [TW-1:0] GMIN_LAST = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_LAST = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] Y_LAST    = TW'(YELLOW - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(ALL_RED - 1);
    // One extra bit so WALK = 2^TW still compares correctly.
    localparam logic [TW:0]   WALK_W    = (TW + 1)'(WALK);

    state_t          state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            pre_dir_reg, pre_dir_next;

    // Per-direction pedestrian state, index 0 = NS, 1 = EW.
    logic [1:0]      ped_req;
    logic [1:0]      ped_pending;
    logic [1:0]      walk_lamp;

    logic            ns_cross;
    logic            ew_cross;
    logic            in_green;
    logic            timer_lt_walk;

    assign ped_req       = {ped_ew_req, ped_ns_req};
    assign ns_cross      = ew_car | ped_pending[1];
    assign ew_cross      = ns_car | ped_pending[0];
    assign in_green      = (state_reg == NS_G) || (state_reg == EW_G);
    assign timer_lt_walk = ({1'b0, timer_reg} < WALK_W);

    // Next-state decision, including preempt direction capture.
    always_comb begin
        state_next   = state_reg;
        pre_dir_next = pre_dir_reg;
        case (state_reg)
            NS_G: begin
                if (emerg_req && emerg_dir) begin
                    state_next = NS_Y;
                end else if (emerg_req) begin
                    state_next   = PRE_G;
                    pre_dir_next = 1'b0;
                end else if (ns_cross && !ns_car && (timer_reg >= GMIN_LAST)) begin
                    state_next = NS_Y;
                end else if (ns_cross && (timer_reg == GMAX_LAST)) begin
                    state_next = NS_Y;
                end
            end
            NS_Y: begin
                if (timer_reg == Y_LAST) state_next = AR1;
            end
            AR1: begin
                if (timer_reg == AR_LAST) begin
                    if (emerg_req) begin
                        state_next   = PRE_G;
                        pre_dir_next = emerg_dir;
                    end else begin
                        state_next = EW_G;
                    end
                end
            end
            EW_G: begin
                if (emerg_req && !emerg_dir) begin
                    state_next = EW_Y;
                end else if (emerg_req) begin
                    state_next   = PRE_G;
                    pre_dir_next = 1'b1;
                end else if (ew_cross && !ew_car && (timer_reg >= GMIN_LAST)) begin
                    state_next = EW_Y;
                end else if (ew_cross && (timer_reg == GMAX_LAST)) begin
                    state_next = EW_Y;
                end
            end
            EW_Y: begin
                if (timer_reg == Y_LAST) state_next = AR2;
            end
            AR2: begin
                if (timer_reg == AR_LAST) begin
                    if (emerg_req) begin
                        state_next   = PRE_G;
                        pre_dir_next = emerg_dir;
                    end else begin
                        state_next = NS_G;
                    end
                end
            end
            PRE_G: begin
                if (!emerg_req) state_next = pre_dir_reg ? EW_Y : NS_Y;
            end
            default: begin
                // Illegal encoding: recover to NS_G; the state change clears the timer.
                state_next = NS_G;
            end
        endcase
    end

    // Phase timer: restart on any state change, saturate in green.
    always_comb begin
        timer_next = timer_reg + 1'b1;
        if (state_next != state_reg) begin
            timer_next = '0;
        end else if (in_green && (timer_reg == GMAX_LAST)) begin
            timer_next = timer_reg;
        end
    end

    // State, timer and preempt direction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= NS_G;
            timer_reg   <= '0;
            pre_dir_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            pre_dir_reg <= pre_dir_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ped
            localparam state_t GREEN_ST = (gi == 0) ? NS_G : EW_G;
            localparam state_t ENTRY_ST = (gi == 0) ? AR2 : AR1;

            logic pending_reg;
            logic walk_flag_reg;
            logic serve_entry;

            // Only the normal clearance path serves pedestrians; PRE_G never does.
            assign serve_entry = (state_reg == ENTRY_ST) && (state_next == GREEN_ST);

            // Latch requests; hand them to the walk flag on entry to the serving green.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pending_reg   <= 1'b0;
                    walk_flag_reg <= 1'b0;
                end else if (serve_entry) begin
                    pending_reg   <= 1'b0;
                    walk_flag_reg <= pending_reg | ped_req[gi];
                end else begin
                    pending_reg   <= pending_reg | ped_req[gi];
                    walk_flag_reg <= (state_next == GREEN_ST) ? walk_flag_reg : 1'b0;
                end
            end

            assign ped_pending[gi] = pending_reg;
            assign walk_lamp[gi]   = (state_reg == GREEN_ST) && walk_flag_reg && timer_lt_walk;
        end
    endgenerate

    // Moore lamp decode from registered state and preempt direction.
    always_comb begin
        ns_red    = 1'b0;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b0;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        case (state_reg)
            NS_G: begin
                ns_green = 1'b1;
                ew_red   = 1'b1;
            end
            NS_Y: begin
                ns_yellow = 1'b1;
                ew_red    = 1'b1;
            end
            AR1, AR2: begin
                ns_red = 1'b1;
                ew_red = 1'b1;
            end
            EW_G: begin
                ew_green = 1'b1;
                ns_red   = 1'b1;
            end
            EW_Y: begin
                ew_yellow = 1'b1;
                ns_red    = 1'b1;
            end
            PRE_G: begin
                ns_green = !pre_dir_reg;
                ns_red   = pre_dir_reg;
                ew_green = pre_dir_reg;
                ew_red   = !pre_dir_reg;
            end
            default: begin
                ns_red = 1'b1;
                ew_red = 1'b1;
            end
        endcase
    end

    assign ns_walk        = walk_lamp[0];
    assign ew_walk        = walk_lamp[1];
    assign ped_ns_pending = ped_pending[0];
    assign ped_ew_pending = ped_pending[1];
    assign preempt_active = (state_reg == PRE_G);
    assign phase          = state_reg;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed testbench for intersection_phase_scheduler with default parameters.
module tb_intersection_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       ns_car, ew_car, ped_ns_req, ped_ew_req, emerg_req, emerg_dir;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
    logic       ns_walk, ew_walk, ped_ns_pending, ped_ew_pending, preempt_active;
    logic [2:0] phase;

    int checks   = 0;
    int failures = 0;

    intersection_phase_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .ns_car         (ns_car),
        .ew_car         (ew_car),
        .ped_ns_req     (ped_ns_req),
        .ped_ew_req     (ped_ew_req),
        .emerg_req      (emerg_req),
        .emerg_dir      (emerg_dir),
        .ns_red         (ns_red),
        .ns_yellow      (ns_yellow),
        .ns_green       (ns_green),
        .ew_red         (ew_red),
        .ew_yellow      (ew_yellow),
        .ew_green       (ew_green),
        .ns_walk        (ns_walk),
        .ew_walk        (ew_walk),
        .ped_ns_pending (ped_ns_pending),
        .ped_ew_pending (ped_ew_pending),
        .preempt_active (preempt_active),
        .phase          (phase)
    );

    always #5 clk = ~clk;

    wire [5:0] lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ns_car = 0; ew_car = 0; ped_ns_req = 0; ped_ew_req = 0;
        emerg_req = 0; emerg_dir = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Tick until the phase changes (bounded); report the phase and its length.
    task automatic run_phase(output logic [2:0] ph, output int len);
        ph  = phase;
        len = 0;
        while (phase == ph && len < 200) begin
            tick();
            len++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ns_car = 0; ew_car = 0; ped_ns_req = 0; ped_ew_req = 0;
        emerg_req = 0; emerg_dir = 0;
        tick();
        checks++;
        if (lamps !== 6'b001100 || phase !== 3'd0 || ns_walk !== 1'b0 || ew_walk !== 1'b0 ||
            preempt_active !== 1'b0 || ped_ns_pending !== 1'b0 || ped_ew_pending !== 1'b0) begin
            $display("FAIL reset_outputs: lamps=%b phase=%0d walk=%b%b pre=%b pend=%b%b required lamps=001100 phase=0 rest 0",
                     lamps, phase, ns_walk, ew_walk, preempt_active, ped_ns_pending, ped_ew_pending);
            failures++;
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (phase !== 3'd0 || lamps !== 6'b001100) begin
            $display("FAIL rest_ns_green: phase=%0d lamps=%b required phase=0 lamps=001100", phase, lamps);
            failures++;
        end
        checks++;
        if (dut.timer_reg !== 5'd23) begin
            $display("FAIL timer_saturate: timer=%0d required 23", dut.timer_reg);
            failures++;
        end
        $display("test_reset done");
    endtask

    task automatic test_forced_cycle();
        logic [2:0] exp_ph [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        int         exp_len[6] = '{24, 4, 2, 24, 4, 2};
        logic [2:0] ph;
        int         len;
        int         total = 0;
        do_reset();
        ns_car = 1; ew_car = 1;
        for (int i = 0; i < 6; i++) begin
            run_phase(ph, len);
            total += len;
            checks++;
            if (ph !== exp_ph[i] || len != exp_len[i]) begin
                $display("FAIL forced_phase%0d: phase=%0d len=%0d required phase=%0d len=%0d",
                         i, ph, len, exp_ph[i], exp_len[i]);
                failures++;
            end
        end
        checks++;
        if (phase !== 3'd0 || total != 60) begin
            $display("FAIL forced_period: phase=%0d period=%0d required phase=0 period=60", phase, total);
            failures++;
        end
        $display("test_forced_cycle done period=%0d", total);
    endtask

    task automatic test_actuated();
        logic [2:0] ph;
        int         len;
        do_reset();
        ew_car = 1;
        run_phase(ph, len);
        checks++;
        if (ph !== 3'd0 || len != 10) begin
            $display("FAIL actuated_green: phase=%0d len=%0d required phase=0 len=10", ph, len);
            failures++;
        end
        run_phase(ph, len);
        run_phase(ph, len);
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (phase !== 3'd3 || lamps !== 6'b100001) begin
            $display("FAIL rest_ew_green: phase=%0d lamps=%b required phase=3 lamps=100001", phase, lamps);
            failures++;
        end
        ew_car = 0;
        $display("test_actuated done");
    endtask

    task automatic test_ped();
        logic [2:0] ph;
        int         len;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        ped_ew_req = 1;
        tick();
        ped_ew_req = 0;
        checks++;
        if (ped_ew_pending !== 1'b1) begin
            $display("FAIL ped_latch: pending=%b required 1", ped_ew_pending);
            failures++;
        end
        run_phase(ph, len);
        checks++;
        if (ph !== 3'd0 || len != 6) begin
            $display("FAIL ped_ns_green_rest: phase=%0d len=%0d required phase=0 len=6", ph, len);
            failures++;
        end
        run_phase(ph, len);
        run_phase(ph, len);
        checks++;
        if (phase !== 3'd3 || ped_ew_pending !== 1'b0) begin
            $display("FAIL ped_serve_entry: phase=%0d pending=%b required phase=3 pending=0", phase, ped_ew_pending);
            failures++;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ew_walk !== 1'b1 || ns_walk !== 1'b0) begin
                $display("FAIL ew_walk_cycle%0d: ew_walk=%b ns_walk=%b required 1 0", i, ew_walk, ns_walk);
                failures++;
            end
            tick();
        end
        checks++;
        if (ew_walk !== 1'b0) begin
            $display("FAIL ew_walk_end: ew_walk=%b required 0", ew_walk);
            failures++;
        end
        ped_ew_req = 1;
        tick();
        ped_ew_req = 0;
        checks++;
        if (ped_ew_pending !== 1'b1 || phase !== 3'd3) begin
            $display("FAIL ped_own_green: pending=%b phase=%0d required pending=1 phase=3", ped_ew_pending, phase);
            failures++;
        end
        ped_ns_req = 1;
        tick();
        ped_ns_req = 0;
        tick();
        checks++;
        if (phase !== 3'd4 || ped_ew_pending !== 1'b1) begin
            $display("FAIL ped_ns_cross_exit: phase=%0d ew_pending=%b required phase=4 pending=1", phase, ped_ew_pending);
            failures++;
        end
        run_phase(ph, len);
        run_phase(ph, len);
        checks++;
        if (phase !== 3'd0 || ns_walk !== 1'b1 || ped_ns_pending !== 1'b0 || ped_ew_pending !== 1'b1) begin
            $display("FAIL ns_serve: phase=%0d ns_walk=%b ns_pend=%b ew_pend=%b required 0 1 0 1",
                     phase, ns_walk, ped_ns_pending, ped_ew_pending);
            failures++;
        end
        run_phase(ph, len);
        checks++;
        if (len != 10) begin
            $display("FAIL ped_actuated_green: len=%0d required 10", len);
            failures++;
        end
        run_phase(ph, len);
        run_phase(ph, len);
        checks++;
        if (phase !== 3'd3 || ew_walk !== 1'b1 || ped_ew_pending !== 1'b0) begin
            $display("FAIL ew_second_serve: phase=%0d ew_walk=%b pending=%b required 3 1 0",
                     phase, ew_walk, ped_ew_pending);
            failures++;
        end
        $display("test_ped done");
    endtask

    task automatic test_preempt_opposite();
        logic [2:0] ph;
        int         len;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        emerg_req = 1; emerg_dir = 1;
        tick();
        checks++;
        if (phase !== 3'd1) begin
            $display("FAIL pre_exit_green: phase=%0d required 1", phase);
            failures++;
        end
        run_phase(ph, len);
        checks++;
        if (len != 4) begin
            $display("FAIL pre_ns_yellow: len=%0d required 4", len);
            failures++;
        end
        run_phase(ph, len);
        checks++;
        if (ph !== 3'd2 || len != 2 || phase !== 3'd6 || lamps !== 6'b100001 || preempt_active !== 1'b1) begin
            $display("FAIL pre_entry: ar_len=%0d phase=%0d lamps=%b pre=%b required 2 6 100001 1",
                     len, phase, lamps, preempt_active);
            failures++;
        end
        emerg_dir = 0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (phase !== 3'd6 || lamps !== 6'b100001 || ew_walk !== 1'b0) begin
            $display("FAIL pre_hold: phase=%0d lamps=%b ew_walk=%b required 6 100001 0", phase, lamps, ew_walk);
            failures++;
        end
        emerg_req = 0;
        tick();
        run_phase(ph, len);
        checks++;
        if (ph !== 3'd4 || len != 4) begin
            $display("FAIL pre_release_yellow: phase=%0d len=%0d required 4 4", ph, len);
            failures++;
        end
        run_phase(ph, len);
        checks++;
        if (ph !== 3'd5 || len != 2 || phase !== 3'd0) begin
            $display("FAIL pre_release_ar: phase=%0d len=%0d next=%0d required 5 2 0", ph, len, phase);
            failures++;
        end
        $display("test_preempt_opposite done");
    endtask

    task automatic test_preempt_matching();
        do_reset();
        tick();
        tick();
        emerg_req = 1; emerg_dir = 0;
        tick();
        checks++;
        if (phase !== 3'd6 || lamps !== 6'b001100 || preempt_active !== 1'b1) begin
            $display("FAIL pre_match: phase=%0d lamps=%b pre=%b required 6 001100 1", phase, lamps, preempt_active);
            failures++;
        end
        emerg_req = 0;
        tick();
        checks++;
        if (phase !== 3'd1 || lamps !== 6'b010100) begin
            $display("FAIL pre_match_release: phase=%0d lamps=%b required 1 010100", phase, lamps);
            failures++;
        end
        $display("test_preempt_matching done");
    endtask

    task automatic test_reset_in_preempt();
        do_reset();
        ped_ns_req = 1; ped_ew_req = 1;
        emerg_req = 1; emerg_dir = 0;
        tick();
        ped_ns_req = 0; ped_ew_req = 0;
        tick();
        checks++;
        if (phase !== 3'd6 || ped_ns_pending !== 1'b1 || ped_ew_pending !== 1'b1 || ns_walk !== 1'b0) begin
            $display("FAIL pre_with_pending: phase=%0d pend=%b%b ns_walk=%b required 6 11 0",
                     phase, ped_ns_pending, ped_ew_pending, ns_walk);
            failures++;
        end
        reset = 1;
        tick();
        checks++;
        if (phase !== 3'd0 || ped_ns_pending !== 1'b0 || ped_ew_pending !== 1'b0 ||
            preempt_active !== 1'b0 || lamps !== 6'b001100) begin
            $display("FAIL reset_in_pre: phase=%0d pend=%b%b pre=%b lamps=%b required 0 00 0 001100",
                     phase, ped_ns_pending, ped_ew_pending, preempt_active, lamps);
            failures++;
        end
        emerg_req = 0;
        reset = 0;
        $display("test_reset_in_preempt done");
    endtask

    initial begin
        test_reset();
        test_forced_cycle();
        test_actuated();
        test_ped();
        test_preempt_opposite();
        test_preempt_matching();
        test_reset_in_preempt();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
